// File: rtl/sid_pkg.sv
// Shared types and constants for the SID host register-write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sid_pkg;

    // One queued host write: target voice, register address, write data.
    typedef struct packed {
        logic [1:0] voice;
        logic [2:0] addr;
        logic [7:0] data;
    } sid_wr_req_t;

    localparam logic [2:0] SID_ADDR_CTRL  = 3'd6;
    localparam logic [1:0] SID_VOICE_FILT = 2'd3;
    localparam int         SID_STROBE_BIT = 7;

    // Field positions inside the raw ui_in bus.
    localparam int SID_VOICE_MSB = 4;
    localparam int SID_VOICE_LSB = 3;
    localparam int SID_ADDR_MSB  = 2;
    localparam int SID_ADDR_LSB  = 0;

    // The filter block only decodes addresses 0..3; 4..7 there are holes.
    function automatic logic sid_req_unmapped(input sid_wr_req_t r);
        return (r.voice == SID_VOICE_FILT) && r.addr[2];
    endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous FIFO of sid_wr_req_t entries, DEPTH a power of 2 (>= 2).
// Latency: a push is visible at dout/level on the following cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
//
// Ports: clk, rst (async, active-high), push/din, pop/dout, full, empty, level.
module sid_wr_fifo
    import sid_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  sid_wr_req_t din,
    input  logic        pop,
    output sid_wr_req_t dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_q, rd_q;
    sid_wr_req_t mem_q [DEPTH];
    logic        push_ok, pop_ok;

    assign pop_ok  = pop & ~empty;
    // A full FIFO can still accept a push when the head leaves on the same edge.
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PTR_ONE;
            if (pop_ok)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign level = wr_q - rd_q;
    assign dout  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/sid_wr_ctrl.sv
// Host write controller: synchronise pin strobe, capture/filter writes, queue them, commit when the datapath is idle.
// Latency: 3 clock edges from first edge sampling the strobe high to the edge registering reg_we.
// Backpressure: slot_busy stalls commits; up to DEPTH writes buffered, further writes dropped with sticky overflow.
//
// Ports: clk, rst (async, active-high); bus_in/data_in raw pins; slot_busy stall;
//        reg_we/reg_voice/reg_addr/reg_data commit port; fifo_level; overflow; gate_on/gate_off pulses.
// Optional feature macro SID_GATE_EVT_EN: per-voice gate edge pulses; when undefined gate_on/gate_off are 0.
module sid_wr_ctrl
    import sid_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               bus_in,
    input  logic [7:0]               data_in,
    input  logic                     slot_busy,
    output logic                     reg_we,
    output logic [1:0]               reg_voice,
    output logic [2:0]               reg_addr,
    output logic [7:0]               reg_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [2:0]               gate_on,
    output logic [2:0]               gate_off
);

    // ---------------- strobe synchroniser and edge detect ----------------
    logic s1_q, s2_q, s3_q;
    logic rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus_in[SID_STROBE_BIT];
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // ---------------- capture and filter ----------------
    // Fields are sampled straight off the pins: the host keeps them stable
    // well past the synchroniser delay, so no extra capture stage is needed.
    sid_wr_req_t req;
    logic        req_vld;

    assign req.voice = bus_in[SID_VOICE_MSB:SID_VOICE_LSB];
    assign req.addr  = bus_in[SID_ADDR_MSB:SID_ADDR_LSB];
    assign req.data  = data_in;
    assign req_vld   = rise & ~sid_req_unmapped(req);

    // bus_in[6:5] carry nothing for this block.
    logic unused_bus;
    assign unused_bus = ^bus_in[6:5];

    // ---------------- FIFO ----------------
    sid_wr_req_t head;
    logic        fifo_full, fifo_empty, pop;

    assign pop = ~fifo_empty & ~slot_busy;

    sid_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_vld),
        .din   (req),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // ---------------- overflow and commit port ----------------
    logic       overflow_q, overflow_d;
    logic       reg_we_q;
    logic [1:0] reg_voice_q;
    logic [2:0] reg_addr_q;
    logic [7:0] reg_data_q;

    assign overflow_d = overflow_q | (req_vld & fifo_full & ~pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_voice_q <= '0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
        end else begin
            overflow_q <= overflow_d;
            reg_we_q   <= pop;
            if (pop) begin
                reg_voice_q <= head.voice;
                reg_addr_q  <= head.addr;
                reg_data_q  <= head.data;
            end
        end
    end

    assign overflow  = overflow_q;
    assign reg_we    = reg_we_q;
    assign reg_voice = reg_voice_q;
    assign reg_addr  = reg_addr_q;
    assign reg_data  = reg_data_q;

    // ---------------- gate edge events ----------------
`ifdef SID_GATE_EVT_EN
    logic [2:0] shadow_q, shadow_d;
    logic [2:0] gate_on_q, gate_on_d;
    logic [2:0] gate_off_q, gate_off_d;
    logic [2:0] vsel;
    logic       gate_hit;
    logic       gbit;

    // Gate bit is data[0] of a voice control register; the filter voice has none.
    assign gate_hit = pop && (head.voice != SID_VOICE_FILT) && (head.addr == SID_ADDR_CTRL);
    assign vsel     = 3'b001 << head.voice;
    assign gbit     = head.data[0];

    always_comb begin
        shadow_d   = shadow_q;
        gate_on_d  = 3'b000;
        gate_off_d = 3'b000;
        if (gate_hit) begin
            gate_on_d  = vsel & {3{gbit}}  & ~shadow_q;
            gate_off_d = vsel & {3{~gbit}} & shadow_q;
            shadow_d   = (shadow_q & ~vsel) | (vsel & {3{gbit}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q   <= 3'b000;
            gate_on_q  <= 3'b000;
            gate_off_q <= 3'b000;
        end else begin
            shadow_q   <= shadow_d;
            gate_on_q  <= gate_on_d;
            gate_off_q <= gate_off_d;
        end
    end

    assign gate_on  = gate_on_q;
    assign gate_off = gate_off_q;
`else
    assign gate_on  = 3'b000;
    assign gate_off = 3'b000;
`endif

endmodule

// File: tb/tb_sid_wr_ctrl.sv
// Self-checking bench for sid_wr_ctrl: directed scenarios plus randomized writes against a queue-based reference model.
// Latency: n/a.
// Backpressure: slot_busy driven directly or randomized per cycle.
module tb_sid_wr_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       slot_busy = 1'b0;
    logic       reg_we;
    logic [1:0] reg_voice;
    logic [2:0] reg_addr;
    logic [7:0] reg_data;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [2:0] gate_on;
    logic [2:0] gate_off;

    always #5 clk = ~clk;

    sid_wr_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .data_in    (data_in),
        .slot_busy  (slot_busy),
        .reg_we     (reg_we),
        .reg_voice  (reg_voice),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .gate_on    (gate_on),
        .gate_off   (gate_off)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int v;
        int a;
        int d;
    } wr_t;

    wr_t mq[$];             // writes currently held in the controller
    wr_t pend;              // write whose push edge is scheduled
    int  push_edge = -1;
    int  edge_cnt  = 0;
    int  exp_we, exp_v, exp_a, exp_d, exp_ovf, exp_on, exp_off;
    int  sh[3];

`ifdef SID_GATE_EVT_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    int  n_chk = 0, n_pass = 0;
    int  obs_we = 0, obs_on2 = 0, obs_off2 = 0;
    int  last_k = 0, last_we_edge = 0, last_gate_on = 0;
    bit  rand_busy = 1'b0;

    function automatic void model_reset();
        mq.delete();
        exp_we = 0; exp_v = 0; exp_a = 0; exp_d = 0;
        exp_ovf = 0; exp_on = 0; exp_off = 0;
        sh = '{0, 0, 0};
        push_edge = -1;
    endfunction

    // One clock edge of spec-level behaviour: commit the oldest write if the
    // slot is free, then accept the scheduled write if there is room.
    function automatic void model_edge(bit busy);
        bit  full_now, pop_now;
        int  g;
        wr_t h;
        full_now = (mq.size() == DEPTH);
        pop_now  = (mq.size() > 0) && !busy;
        exp_we = 0; exp_on = 0; exp_off = 0;
        if (pop_now) begin
            h = mq.pop_front();
            exp_we = 1; exp_v = h.v; exp_a = h.a; exp_d = h.d;
            if (GATE_EN && h.v < 3 && h.a == 6) begin
                g = h.d % 2;
                if (g == 1 && sh[h.v] == 0) exp_on  = 1 << h.v;
                if (g == 0 && sh[h.v] == 1) exp_off = 1 << h.v;
                sh[h.v] = g;
            end
        end
        if (push_edge == edge_cnt) begin
            push_edge = -1;
            if (!(pend.v == 3 && pend.a >= 4)) begin
                if (!full_now || pop_now) mq.push_back(pend);
                else exp_ovf = 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock edge, step the model, then compare every output.
    task automatic cyc();
        bit b;
        if (rand_busy) slot_busy = ($urandom_range(0, 3) == 0);
        b = slot_busy;
        @(posedge clk);
        edge_cnt++;
        if (rst) model_reset();
        else     model_edge(b);
        #2;
        chk("reg_we",     int'(reg_we),     exp_we);
        chk("reg_voice",  int'(reg_voice),  exp_v);
        chk("reg_addr",   int'(reg_addr),   exp_a);
        chk("reg_data",   int'(reg_data),   exp_d);
        chk("fifo_level", int'(fifo_level), mq.size());
        chk("overflow",   int'(overflow),   exp_ovf);
        chk("gate_on",    int'(gate_on),    exp_on);
        chk("gate_off",   int'(gate_off),   exp_off);
        if (reg_we) begin
            obs_we++;
            last_we_edge = edge_cnt;
            last_gate_on = int'(gate_on);
        end
        if (gate_on[2])  obs_on2++;
        if (gate_off[2]) obs_off2++;
    endtask

    // Host write honouring the pin contract: fields set one cycle ahead,
    // strobe high 2 cycles, then low with fields held.
    task automatic wr(input int v, input int a, input int d);
        bus_in  = {1'b0, 2'b00, 2'(v), 3'(a)};
        data_in = 8'(d);
        cyc();
        bus_in[7] = 1'b1;
        pend      = '{v, a, d};
        last_k    = edge_cnt + 1;
        push_edge = edge_cnt + 3;
        cyc();
        cyc();
        bus_in[7] = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    int o, mc;

    initial begin
        model_reset();
        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Single write, check latency and drain
        o = obs_we;
        wr(0, 0, 'hD6);
        chk("t1_latency", last_we_edge - last_k, 3);
        chk("t1_commits", obs_we - o, 1);
        chk("t1_level", int'(fifo_level), 0);

        // 11-write register programming sequence ending on a gate-on
        o = obs_we;
        wr(0, 0, 'hD6); wr(0, 1, 'h1C); wr(0, 2, 'h00);
        wr(0, 3, 'h08); wr(0, 4, 'h00); wr(0, 5, 'hF0);
        wr(3, 0, 'h00); wr(3, 1, 'h00); wr(3, 2, 'h00); wr(3, 3, 'h0F);
        wr(0, 6, 'h11);
        cyc(); cyc();
        chk("t2_commits", obs_we - o, 11);
        chk("t2_last_gate_on", last_gate_on, GATE_EN ? 1 : 0);

        // Stall with 5 writes into a 4-deep queue
        slot_busy = 1'b1;
        o = obs_we;
        wr(1, 0, 'h01); wr(1, 1, 'h02); wr(1, 2, 'h03); wr(1, 3, 'h04); wr(1, 4, 'h05);
        chk("t3_level_full", int'(fifo_level), 4);
        chk("t3_overflow", int'(overflow), 1);
        chk("t3_no_commit", obs_we - o, 0);
        slot_busy = 1'b0;
        repeat (6) cyc();
        chk("t3_commits", obs_we - o, 4);

        // Unmapped filter-voice address is discarded
        pulse_reset();
        o = obs_we;
        wr(3, 5, 'hAA);
        cyc();
        chk("t4_commits", obs_we - o, 0);
        chk("t4_overflow", int'(overflow), 0);
        chk("t4_level", int'(fifo_level), 0);

        // Gate on, gate off, repeated off
        obs_on2 = 0; obs_off2 = 0;
        wr(2, 6, 'h41);
        chk("t5_on_pulses", obs_on2, GATE_EN ? 1 : 0);
        wr(2, 6, 'h40);
        chk("t5_off_pulses", obs_off2, GATE_EN ? 1 : 0);
        wr(2, 6, 'h40);
        chk("t5_repeat_on", obs_on2, GATE_EN ? 1 : 0);
        chk("t5_repeat_off", obs_off2, GATE_EN ? 1 : 0);

        // Randomized writes with random slot occupancy
        o = obs_we;
        mc = mq.size();
        rand_busy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255));
        end
        rand_busy = 1'b0;
        slot_busy = 1'b0;
        repeat (8) cyc();
        chk("t6_drained", int'(fifo_level), 0);

        // Asynchronous reset with 2 queued writes and a strobe mid-high
        slot_busy = 1'b1;
        wr(1, 1, 'h11);
        wr(1, 2, 'h22);
        chk("t7_level_pre", int'(fifo_level), 2);
        bus_in  = {1'b0, 2'b00, 2'd2, 3'd3};
        data_in = 8'h5A;
        cyc();
        bus_in[7] = 1'b1;
        pend = '{2, 3, 'h5A};
        push_edge = edge_cnt + 3;
        cyc();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("t7_async_we",    int'(reg_we),     0);
        chk("t7_async_data",  int'(reg_data),   0);
        chk("t7_async_voice", int'(reg_voice),  0);
        chk("t7_async_addr",  int'(reg_addr),   0);
        chk("t7_async_level", int'(fifo_level), 0);
        chk("t7_async_ovf",   int'(overflow),   0);
        chk("t7_async_gon",   int'(gate_on),    0);
        chk("t7_async_goff",  int'(gate_off),   0);
        cyc();
        cyc();
        rst = 1'b0;
        slot_busy = 1'b0;
        o = obs_we;
        push_edge = edge_cnt + 3;
        cyc(); cyc(); cyc();
        bus_in[7] = 1'b0;
        repeat (5) cyc();
        chk("t7_commits_after", obs_we - o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
